gray_seq_gen: RTL and testbench
===============================

# gray_seq_gen

Synchronous Gray-code sequence generator that emits a programmable run of consecutive Gray codes over a valid/ready stream. It sits directly upstream of the `gry_to_bin` converter: `Gry` from this block drives the converter's `Gry` input, with matching `wid`. A run is set by a binary start value, a direction and a length. The block handles wrap-around, downstream back-pressure and completion signalling.

## Interface
- `wid`, 4, code width in bits; must be ≥ 2.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a new run; sampled only in IDLE.
- `first`  in  wid  binary value of the first code; captured with `start`.
- `up`  in  1  direction: 1 counts up, 0 counts down; captured with `start`.
- `len`  in  wid+1  number of codes to emit, 0 … 2^(wid+1)−1; captured with `start`.
- `Gry`  out  wid  current Gray code, registered.
- `gry_valid`  out  1  `Gry` holds a code to be transferred.
- `gry_ready`  in  1  downstream accepts `Gry` this cycle.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse marking the end of a run.
- `wrap`  out  1  high while the presented `Gry` is the first code after a wrap-around.

## Operation
- Internal state:
  - binary counter `b` (wid bits);
  - remaining count `rem` (wid+1 bits);
  - direction register `dir`.
- `Gry` is always registered as `b ^ (b >> 1)`.
- A handshake is `gry_valid && gry_ready` in the same cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE, `start` = 1:
  - Capture `b` ← `first`, `dir` ← `up`, `rem` ← `len`.
  - If `len` = 0, go to DONE.
  - Otherwise go to RUN.
- IDLE, `start` = 0: stay in IDLE; all outputs hold.
- RUN:
  - `gry_valid` = 1.
  - No handshake: hold all state and `Gry`.
  - Handshake with `rem` = 1: go to DONE.
  - Handshake with `rem` > 1: `rem` ← `rem` − 1; `b` ← `b` ± 1 modulo 2^wid.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- `start` is ignored while `busy` = 1; it is not queued.
- Wrap-around:
  - Up direction: `b` going 2^wid−1 → 0.
  - Down direction: `b` going 0 → 2^wid−1.
  - `wrap` is registered. It is high in the cycle the post-wrap code is presented and stays high while that code is stalled.
  - `wrap` clears on the next handshake or on leaving RUN.
- `len` > 2^wid produces multiple wraps; each wrap is flagged.
- `Gry` keeps the last emitted code in DONE and IDLE. Downstream must qualify `Gry` with `gry_valid`.
- `len`, `first` and `up` may change freely outside the `start` capture cycle.

## Timing
- Reset (`rst` high at an edge), effective from the following cycle:
  - state = IDLE;
  - `Gry`, `gry_valid`, `busy`, `done`, `wrap` = 0;
  - `b`, `rem` = 0.
- `rst` has priority over every other input, including in the middle of a run. An in-flight code is dropped without `done`.
- `start` sampled at edge T:
  - `len` ≠ 0: `gry_valid` = 1 with Gray(`first`) from cycle T+1; `busy` = 1 from T+1.
  - `len` = 0: `done` = 1 and `busy` = 1 in cycle T+1; `gry_valid` never asserts.
- Throughput: with `gry_ready` held high, one code per cycle, no bubbles.
- Last handshake at edge T: `gry_valid` = 0 and `done` = 1 in cycle T+1; IDLE (`busy` = 0) in T+2.
- Earliest next start: `start` sampled at edge T+2.
- `gry_valid` never drops while in RUN; `Gry` is stable while `gry_valid && !gry_ready`.

## Test plan
- **Reset:** `rst` high 2 cycles mid-run (wid=4, `len`=10, after 3 codes) → next cycle all outputs 0; no `done` pulse; a new `start` then works normally.
- **Full cycle up:** wid=4, `first`=0, `up`=1, `len`=16, `gry_ready`=1 → 16 consecutive valid codes 0000, 0001, 0011, 0010, 0110 … 1001, 1000; a `gry_to_bin` instance reads 0…15 in order; `done` one cycle after the last code; `wrap` never high.
- **Wrap up:** wid=3, `first`=6, `up`=1, `len`=4 → 101, 100, 000, 001; `wrap`=1 only while 000 is presented.
- **Wrap down:** wid=3, `first`=1, `up`=0, `len`=3 → 001, 000, 100; `wrap`=1 only with 100; `done` pulse follows.
- **Back-pressure:** wid=4, `first`=5, `len`=3, `gry_ready` pattern 1,0,0,1,1 → codes 0111, 0110 (held 3 cycles, stable), 0010; no skipped or duplicated codes. Additionally, `start` pulsed during the run is ignored.
- **Zero length:** `len`=0 with `start` → `done` high in the next cycle, `gry_valid` stays 0, `busy` low again in the cycle after.

Source files
------------

// File: rtl/gray_seq_gen_if.sv
// gray_seq_gen_if: run request, Gray-code stream and status bundle for gray_seq_gen.
// latency: none, wires only.
// backpressure: gry_ready from the consumer stalls the stream; the generator holds Gry while stalled.
interface gray_seq_gen_if #(
  parameter int WID = 4
);
  // run request
  logic           start;
  logic [WID-1:0] first;
  logic           up;
  logic [WID:0]   len;
  // code stream
  logic [WID-1:0] Gry;
  logic           gry_valid;
  logic           gry_ready;
  // status
  logic           busy;
  logic           done;
  logic           wrap;

  // generator side
  modport master (
    input  start, first, up, len, gry_ready,
    output Gry, gry_valid, busy, done, wrap
  );

  // requester / consumer side
  modport slave (
    output start, first, up, len, gry_ready,
    input  Gry, gry_valid, busy, done, wrap
  );
endinterface

// File: rtl/gray_seq_gen.sv
// gray_seq_gen: emits a run of len consecutive Gray codes, starting at Gray(first), counting up or down.
// latency: first code valid one cycle after start; done pulses one cycle after the last handshake.
// backpressure: Gry, wrap and all counters hold while gry_valid && !gry_ready; start is ignored while busy.
module gray_seq_gen #(
  parameter int WID = 4  // code width, must be >= 2 and match the interface instance
) (
  input  logic           clk,
  input  logic           rst,
  gray_seq_gen_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WID-1:0] B_ONE   = {{(WID-1){1'b0}}, 1'b1};
  localparam logic [WID-1:0] B_ZERO  = '0;
  localparam logic [WID-1:0] B_MAX   = '1;
  localparam logic [WID:0]   REM_ONE = {{WID{1'b0}}, 1'b1};
  localparam logic [WID:0]   REM_ZERO = '0;

  logic [1:0]     state;
  logic [WID-1:0] b;        // binary position of the presented code
  logic [WID:0]   rem;      // codes still to be handed over, including the presented one
  logic           dir;      // 1 = count up
  logic [WID-1:0] gry_q;
  logic           wrap_q;

  logic           hs;
  logic [WID-1:0] b_nxt;
  logic           wrap_nxt;

  assign hs = (state == ST_RUN) && bus.gry_ready;

  // next binary position and whether stepping to it crosses the modulo boundary
  always_comb begin
    b_nxt    = dir ? (b + B_ONE) : (b - B_ONE);
    wrap_nxt = dir ? (b == B_MAX) : (b == B_ZERO);
  end

  // run FSM with the counter, remaining count, registered Gry and wrap flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      b      <= '0;
      rem    <= '0;
      dir    <= 1'b0;
      gry_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            b      <= bus.first;
            gry_q  <= bus.first ^ (bus.first >> 1);
            dir    <= bus.up;
            rem    <= bus.len;
            wrap_q <= 1'b0;
            state  <= (bus.len == REM_ZERO) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (hs) begin
            if (rem == REM_ONE) begin
              // last code accepted: Gry keeps that code, wrap drops with RUN
              state  <= ST_DONE;
              wrap_q <= 1'b0;
            end else begin
              rem    <= rem - REM_ONE;
              b      <= b_nxt;
              gry_q  <= b_nxt ^ (b_nxt >> 1);
              wrap_q <= wrap_nxt;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          wrap_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          wrap_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Gry       = gry_q;
  assign bus.gry_valid = (state == ST_RUN);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_gray_seq_gen.sv
// tb_gray_seq_gen: scoreboard bench for gray_seq_gen at WID=4 and WID=3.
// Expected codes/wrap flags are queued when a run is started and popped on each handshake.
// Inputs are driven 1 time unit after posedge, outputs sampled on negedge.
module tb_gray_seq_gen;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] exp_q[$];
  bit         expw_q[$];

  gray_seq_gen_if #(.WID(4)) a4();
  gray_seq_gen_if #(.WID(3)) a3();

  gray_seq_gen #(.WID(4)) dut4 (.clk(clk), .rst(rst), .bus(a4.master));
  gray_seq_gen #(.WID(3)) dut3 (.clk(clk), .rst(rst), .bus(a3.master));

  always #5 clk = ~clk;

  // gry_to_bin reference: binary is the XOR of all right shifts of the Gray code
  function automatic int g2b(input logic [3:0] g);
    int r;
    r = int'(g);
    for (int s = 1; s < 4; s++) r = r ^ (int'(g) >> s);
    return r;
  endfunction

  task automatic test_reset();
    int cyc;
    int n;
    // power-on reset
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({a4.Gry, a4.gry_valid, a4.busy, a4.done, a4.wrap} !== 8'd0)
      begin errors++; $display("FAIL por_outputs: got %b want 00000000", {a4.Gry, a4.gry_valid, a4.busy, a4.done, a4.wrap}); end
    @(posedge clk); #1;
    rst = 1'b0;

    // mid-run reset after 3 codes of a len=10 run
    exp_q.delete(); expw_q.delete();
    for (int i = 0; i < 10; i++) begin exp_q.push_back(4'(i ^ (i >> 1))); expw_q.push_back(1'b0); end
    a4.first = 4'd0; a4.up = 1'b1; a4.len = 5'd10; a4.gry_ready = 1'b1; a4.start = 1'b1;
    @(posedge clk); #1;
    a4.start = 1'b0;
    cyc = 0; n = 0;
    while (n < 3 && cyc < 40) begin
      @(negedge clk); cyc++;
      checks++;
      if (a4.Gry !== exp_q[0]) begin errors++; $display("FAIL rst_prerun_code: got %b want %b", a4.Gry, exp_q[0]); end
      if (a4.gry_valid && a4.gry_ready) begin void'(exp_q.pop_front()); void'(expw_q.pop_front()); n++; end
      @(posedge clk); #1;
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL rst_prerun_timeout: got %0d codes want 3", n); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a4.Gry, a4.gry_valid, a4.busy, a4.done, a4.wrap} !== 8'd0)
      begin errors++; $display("FAIL rst_midrun_outputs: got %b want 00000000", {a4.Gry, a4.gry_valid, a4.busy, a4.done, a4.wrap}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a4.gry_valid, a4.busy, a4.done} !== 3'b000)
      begin errors++; $display("FAIL rst_no_done: valid/busy/done got %b want 000", {a4.gry_valid, a4.busy, a4.done}); end

    // a fresh run works after reset: first=3, len=2 -> 0010, 0110
    exp_q.delete(); expw_q.delete();
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0110);
    @(posedge clk); #1;
    a4.first = 4'd3; a4.up = 1'b1; a4.len = 5'd2; a4.start = 1'b1;
    @(posedge clk); #1;
    a4.start = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      checks++;
      if (a4.gry_valid !== 1'b1 || a4.Gry !== exp_q[0])
        begin errors++; $display("FAIL rst_rerun_code: got valid=%b code=%b want valid=1 code=%b", a4.gry_valid, a4.Gry, exp_q[0]); end
      if (a4.gry_valid && a4.gry_ready) void'(exp_q.pop_front());
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rst_rerun_timeout: %0d codes left want 0", exp_q.size()); end
    @(negedge clk);
    checks++;
    if (a4.done !== 1'b1) begin errors++; $display("FAIL rst_rerun_done: got %b want 1", a4.done); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_up();
    int cyc;
    int k;
    exp_q.delete(); expw_q.delete();
    for (int i = 0; i < 16; i++) begin exp_q.push_back(4'(i ^ (i >> 1))); expw_q.push_back(1'b0); end
    a4.first = 4'd0; a4.up = 1'b1; a4.len = 5'd16; a4.gry_ready = 1'b1; a4.start = 1'b1;
    @(posedge clk); #1;
    a4.start = 1'b0;
    cyc = 0; k = 0;
    while (exp_q.size() > 0 && cyc < 64) begin
      @(negedge clk); cyc++;
      checks++;
      if (a4.gry_valid !== 1'b1) begin errors++; $display("FAIL full_up_valid: got %b want 1 (code %0d)", a4.gry_valid, k); end
      checks++;
      if (a4.Gry !== exp_q[0]) begin errors++; $display("FAIL full_up_code: got %b want %b", a4.Gry, exp_q[0]); end
      checks++;
      if (g2b(a4.Gry) != k) begin errors++; $display("FAIL full_up_bin: got %0d want %0d", g2b(a4.Gry), k); end
      checks++;
      if (a4.wrap !== expw_q[0]) begin errors++; $display("FAIL full_up_wrap: got %b want %b", a4.wrap, expw_q[0]); end
      if (a4.gry_valid && a4.gry_ready) begin void'(exp_q.pop_front()); void'(expw_q.pop_front()); k++; end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL full_up_timeout: %0d codes left want 0", exp_q.size()); end
    @(negedge clk);
    checks++;
    if ({a4.done, a4.gry_valid, a4.busy} !== 3'b101)
      begin errors++; $display("FAIL full_up_done: done/valid/busy got %b want 101", {a4.done, a4.gry_valid, a4.busy}); end
    @(negedge clk);
    checks++;
    if ({a4.done, a4.busy} !== 2'b00) begin errors++; $display("FAIL full_up_idle: done/busy got %b want 00", {a4.done, a4.busy}); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int cyc;
    for (int s = 0; s < 2; s++) begin
      exp_q.delete(); expw_q.delete();
      if (s == 0) begin
        // up from 6: 101, 100, 000(wrap), 001
        a3.first = 3'd6; a3.up = 1'b1; a3.len = 4'd4;
        exp_q = '{4'b0101, 4'b0100, 4'b0000, 4'b0001};
        expw_q = '{1'b0, 1'b0, 1'b1, 1'b0};
      end else begin
        // down from 1: 001, 000, 100(wrap)
        a3.first = 3'd1; a3.up = 1'b0; a3.len = 4'd3;
        exp_q = '{4'b0001, 4'b0000, 4'b0100};
        expw_q = '{1'b0, 1'b0, 1'b1};
      end
      a3.gry_ready = 1'b1; a3.start = 1'b1;
      @(posedge clk); #1;
      a3.start = 1'b0;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 20) begin
        @(negedge clk); cyc++;
        checks++;
        if (a3.gry_valid !== 1'b1 || {1'b0, a3.Gry} !== exp_q[0])
          begin errors++; $display("FAIL wrap%0d_code: got valid=%b code=%b want valid=1 code=%b", s, a3.gry_valid, a3.Gry, exp_q[0][2:0]); end
        checks++;
        if (a3.wrap !== expw_q[0]) begin errors++; $display("FAIL wrap%0d_flag: got %b want %b at code %b", s, a3.wrap, expw_q[0], exp_q[0][2:0]); end
        if (a3.gry_valid && a3.gry_ready) begin void'(exp_q.pop_front()); void'(expw_q.pop_front()); end
        @(posedge clk); #1;
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL wrap%0d_timeout: %0d codes left want 0", s, exp_q.size()); end
      @(negedge clk);
      checks++;
      if ({a3.done, a3.gry_valid, a3.wrap} !== 3'b100)
        begin errors++; $display("FAIL wrap%0d_done: done/valid/wrap got %b want 100", s, {a3.done, a3.gry_valid, a3.wrap}); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_pressure();
    int cyc;
    int c;
    bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_q.delete(); expw_q.delete();
    exp_q = '{4'b0111, 4'b0110, 4'b0010};
    a4.first = 4'd5; a4.up = 1'b0; a4.len = 5'd3; a4.start = 1'b1;
    a4.gry_ready = pat[0];
    @(posedge clk); #1;
    a4.start = 1'b0;
    cyc = 0; c = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      checks++;
      if (a4.gry_valid !== 1'b1 || a4.Gry !== exp_q[0])
        begin errors++; $display("FAIL bp_code: cycle %0d got valid=%b code=%b want valid=1 code=%b", c, a4.gry_valid, a4.Gry, exp_q[0]); end
      if (a4.gry_valid && a4.gry_ready) void'(exp_q.pop_front());
      @(posedge clk); #1;
      c++;
      a4.gry_ready = (c < 5) ? pat[c] : 1'b1;
      // start pulse mid-run with different parameters must be ignored
      if (c == 1) begin a4.start = 1'b1; a4.first = 4'hF; a4.up = 1'b1; a4.len = 5'd5; end
      if (c == 2) a4.start = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_timeout: %0d codes left want 0", exp_q.size()); end
    checks++;
    if (c != 5) begin errors++; $display("FAIL bp_cycles: run took %0d cycles want 5", c); end
    @(negedge clk);
    checks++;
    if ({a4.done, a4.gry_valid} !== 2'b10) begin errors++; $display("FAIL bp_done: done/valid got %b want 10", {a4.done, a4.gry_valid}); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({a4.busy, a4.gry_valid, a4.done} !== 3'b000)
      begin errors++; $display("FAIL bp_start_ignored: busy/valid/done got %b want 000", {a4.busy, a4.gry_valid, a4.done}); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_len();
    a4.first = 4'd9; a4.up = 1'b1; a4.len = 5'd0; a4.gry_ready = 1'b1; a4.start = 1'b1;
    @(posedge clk); #1;
    a4.start = 1'b0;
    @(negedge clk);
    checks++;
    if ({a4.done, a4.busy, a4.gry_valid} !== 3'b110)
      begin errors++; $display("FAIL zero_len_done: done/busy/valid got %b want 110", {a4.done, a4.busy, a4.gry_valid}); end
    @(negedge clk);
    checks++;
    if ({a4.done, a4.busy, a4.gry_valid} !== 3'b000)
      begin errors++; $display("FAIL zero_len_idle: done/busy/valid got %b want 000", {a4.done, a4.busy, a4.gry_valid}); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    a4.start = 1'b0; a4.first = '0; a4.up = 1'b0; a4.len = '0; a4.gry_ready = 1'b0;
    a3.start = 1'b0; a3.first = '0; a3.up = 1'b0; a3.len = '0; a3.gry_ready = 1'b0;
    test_reset();
    test_full_up();
    test_wrap();
    test_back_pressure();
    test_zero_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
